// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 mode defaults, derived totals,
// colour field positions and the sync/enable bundle carried down the pipeline.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_DATA_LAT = 1;
  localparam int unsigned DEF_FCNT_W   = 8;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned R_LSB   = 16;
  localparam int unsigned G_LSB   = 8;
  localparam int unsigned B_LSB   = 0;

  // Total period of one axis in counter ticks
  function automatic int unsigned span_total(input int unsigned sync, input int unsigned bp,
                                             input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

  // Bits needed to count 0..total-1
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 2) ? $clog2(total) : 1;
  endfunction

  localparam int unsigned DEF_H_TOTAL = span_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int unsigned DEF_V_TOTAL = span_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the timing generator and the frame buffer / ROM.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] h_addr;
  logic [ADDR_W-1:0] v_addr;
  logic              req_valid;
  logic [RGB_W-1:0]  vga_data;

  modport master (output h_addr, output v_addr, output req_valid, input vga_data);
  modport slave  (input h_addr, input v_addr, input req_valid, output vga_data);

endinterface

// File: rtl/vga_sync_pipe.sv
// DEPTH-stage delay line with a loadable reset value; keeps sync/enable in
// step with frame-buffer read latency.
module vga_sync_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= rst_val;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: issues pixel addresses DATA_LAT cycles
// ahead of display and delays sync/enable to line up with returned pixel data.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned DATA_LAT = DEF_DATA_LAT,
  parameter int unsigned FCNT_W   = DEF_FCNT_W
) (
  input  logic                pclk,
  input  logic                reset_n,
  vga_timing_gen_if.master    fb,
  output logic                hsync,
  output logic                vsync,
  output logic                valid,
  output logic [COLOR_W-1:0]  vga_r,
  output logic [COLOR_W-1:0]  vga_g,
  output logic [COLOR_W-1:0]  vga_b,
  output logic                v_end,
  output logic                frame_start,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int unsigned V_TOTAL = span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int unsigned HC_W    = cnt_width(H_TOTAL);
  localparam int unsigned VC_W    = cnt_width(V_TOTAL);
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            h_last;
  logic            v_last;

  assign h_last = (h_cnt == HC_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == VC_W'(V_TOTAL - 1));

  // Raster counters; reset discards any partial frame
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end else begin
        v_cnt <= v_cnt + VC_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + HC_W'(1);
    end
  end

  logic            h_act;
  logic            v_act;
  logic            req;
  logic [HC_W-1:0] h_off;
  logic [VC_W-1:0] v_off;
  sync_t           raw;
  sync_t           dly;
  sync_t           rst_val;

  // Request stage; compares are one bit wider so an active region that ends
  // exactly at the total period still decodes correctly
  always_comb begin
    h_act = ({1'b0, h_cnt} >= (HC_W+1)'(H_START)) && ({1'b0, h_cnt} < (HC_W+1)'(H_END));
    v_act = ({1'b0, v_cnt} >= (VC_W+1)'(V_START)) && ({1'b0, v_cnt} < (VC_W+1)'(V_END));
    req   = h_act && v_act;
    h_off = h_cnt - HC_W'(H_START);
    v_off = v_cnt - VC_W'(V_START);
    fb.req_valid = req;
    fb.h_addr    = '0;
    fb.v_addr    = '0;
    if (req) begin
      fb.h_addr = ADDR_W'(h_off);
      fb.v_addr = ADDR_W'(v_off);
    end
    raw.hs = (h_cnt < HC_W'(H_SYNC)) ? H_POL : ~H_POL;
    raw.vs = (v_cnt < VC_W'(V_SYNC)) ? V_POL : ~V_POL;
    raw.de = req;
  end

  assign rst_val = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  vga_sync_pipe #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (DATA_LAT)
  ) u_sync_pipe (
    .clk     (pclk),
    .rst_n   (reset_n),
    .rst_val (rst_val),
    .din     (raw),
    .dout    (dly)
  );

  assign hsync = dly.hs;
  assign vsync = dly.vs;
  assign valid = dly.de;

  assign vga_r = dly.de ? fb.vga_data[R_LSB +: COLOR_W] : '0;
  assign vga_g = dly.de ? fb.vga_data[G_LSB +: COLOR_W] : '0;
  assign vga_b = dly.de ? fb.vga_data[B_LSB +: COLOR_W] : '0;

  assign v_end       = ~v_act;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0) && reset_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three generator instances (small mode lat 1, small mode lat 3 with
// active-high sync, default 640x480) against a time-based raster model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int lat, fw;
    bit hpol, vpol;
  } mode_t;

  typedef struct {
    logic [31:0] h_addr, v_addr, req, hsync, vsync, valid;
    logic [31:0] r, g, b, v_end, fs, fc;
  } sig_t;

  logic clk;
  logic reset_n;
  logic [23:0] key;
  int n_tests, n_fail, pos;
  bit started;
  mode_t mode_a, mode_b, mode_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  logic hs_a, vs_a, de_a, ve_a, fs_a;
  logic hs_b, vs_b, de_b, ve_b, fs_b;
  logic hs_c, vs_c, de_c, ve_c, fs_c;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic [7:0] fc_a, fc_c;
  logic [1:0] fc_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .DATA_LAT(1), .FCNT_W(8)
  ) dut_a (
    .pclk(clk), .reset_n(reset_n), .fb(if_a),
    .hsync(hs_a), .vsync(vs_a), .valid(de_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .v_end(ve_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .DATA_LAT(3), .FCNT_W(2)
  ) dut_b (
    .pclk(clk), .reset_n(reset_n), .fb(if_b),
    .hsync(hs_b), .vsync(vs_b), .valid(de_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .v_end(ve_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing_gen dut_c (
    .pclk(clk), .reset_n(reset_n), .fb(if_c),
    .hsync(hs_c), .vsync(vs_c), .valid(de_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
    .v_end(ve_c), .frame_start(fs_c), .frame_cnt(fc_c)
  );

  // Pixel colour stored at (x, y) in the model frame buffer
  function automatic logic [23:0] color(input int x, input int y, input logic [23:0] k);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb ^ k[23:16], yb ^ k[15:8], 8'(xb + yb) ^ k[7:0]};
  endfunction

  // Synchronous frame-buffer models with read latency matching each instance
  logic [23:0] ram_a, ram_c;
  logic [23:0] ram_b [3];
  always @(posedge clk) begin
    ram_a    <= color(int'(if_a.h_addr), int'(if_a.v_addr), key);
    ram_c    <= color(int'(if_c.h_addr), int'(if_c.v_addr), key);
    ram_b[0] <= color(int'(if_b.h_addr), int'(if_b.v_addr), key);
    ram_b[1] <= ram_b[0];
    ram_b[2] <= ram_b[1];
  end
  assign if_a.vga_data = ram_a;
  assign if_b.vga_data = ram_b[2];
  assign if_c.vga_data = ram_c;

  // Expected outputs from the number of cycles the raster has run since reset
  function automatic sig_t model(input mode_t m, input int p_run, input bit rst_n,
                                 input logic [23:0] k);
    sig_t e;
    int ht, vt, fr, p, h, v, q, hd, vd, hst, vst;
    bit h_in, v_in, vis;
    logic [23:0] c;
    ht  = m.hs + m.hbp + m.ha + m.hfp;
    vt  = m.vs + m.vbp + m.va + m.vfp;
    fr  = ht * vt;
    hst = m.hs + m.hbp;
    vst = m.vs + m.vbp;
    p = p_run % fr;
    h = p % ht;
    v = p / ht;
    h_in = (h >= hst) && (h < hst + m.ha);
    v_in = (v >= vst) && (v < vst + m.va);
    e.req    = 32'(h_in && v_in);
    e.h_addr = (h_in && v_in) ? 32'(h - hst) : 32'd0;
    e.v_addr = (h_in && v_in) ? 32'(v - vst) : 32'd0;
    e.v_end  = 32'(!v_in);
    e.fs     = 32'((p == 0) && rst_n);
    e.fc     = 32'((p_run / fr) % (1 << m.fw));
    if (p_run < m.lat) begin
      e.hsync = 32'(!m.hpol);
      e.vsync = 32'(!m.vpol);
      e.valid = 32'd0;
      c = 24'd0;
    end else begin
      q  = (p_run - m.lat) % fr;
      hd = q % ht;
      vd = q / ht;
      vis = (hd >= hst) && (hd < hst + m.ha) && (vd >= vst) && (vd < vst + m.va);
      e.hsync = 32'((hd < m.hs) ? m.hpol : !m.hpol);
      e.vsync = 32'((vd < m.vs) ? m.vpol : !m.vpol);
      e.valid = 32'(vis);
      c = vis ? color(hd - hst, vd - vst, k) : 24'd0;
    end
    e.r = 32'(c[23:16]);
    e.g = 32'(c[15:8]);
    e.b = 32'(c[7:0]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at pos %0d: got %0h expected %0h", tag, pos, got, exp);
    end
  endtask

  task automatic cmp(input string n, input sig_t o, input sig_t e);
    check({n, ".h_addr"},      o.h_addr, e.h_addr);
    check({n, ".v_addr"},      o.v_addr, e.v_addr);
    check({n, ".req_valid"},   o.req,    e.req);
    check({n, ".hsync"},       o.hsync,  e.hsync);
    check({n, ".vsync"},       o.vsync,  e.vsync);
    check({n, ".valid"},       o.valid,  e.valid);
    check({n, ".vga_r"},       o.r,      e.r);
    check({n, ".vga_g"},       o.g,      e.g);
    check({n, ".vga_b"},       o.b,      e.b);
    check({n, ".v_end"},       o.v_end,  e.v_end);
    check({n, ".frame_start"}, o.fs,     e.fs);
    check({n, ".frame_cnt"},   o.fc,     e.fc);
  endtask

  sig_t obs_a, obs_b, obs_c;
  always_comb begin
    obs_a = '{h_addr: 32'(if_a.h_addr), v_addr: 32'(if_a.v_addr), req: 32'(if_a.req_valid),
              hsync: 32'(hs_a), vsync: 32'(vs_a), valid: 32'(de_a), r: 32'(r_a), g: 32'(g_a),
              b: 32'(b_a), v_end: 32'(ve_a), fs: 32'(fs_a), fc: 32'(fc_a)};
    obs_b = '{h_addr: 32'(if_b.h_addr), v_addr: 32'(if_b.v_addr), req: 32'(if_b.req_valid),
              hsync: 32'(hs_b), vsync: 32'(vs_b), valid: 32'(de_b), r: 32'(r_b), g: 32'(g_b),
              b: 32'(b_b), v_end: 32'(ve_b), fs: 32'(fs_b), fc: 32'(fc_b)};
    obs_c = '{h_addr: 32'(if_c.h_addr), v_addr: 32'(if_c.v_addr), req: 32'(if_c.req_valid),
              hsync: 32'(hs_c), vsync: 32'(vs_c), valid: 32'(de_c), r: 32'(r_c), g: 32'(g_c),
              b: 32'(b_c), v_end: 32'(ve_c), fs: 32'(fs_c), fc: 32'(fc_c)};
  end

  // One pixel clock: drive reset_n, compare mid-cycle, then advance the model
  task automatic step(input bit r);
    reset_n = r;
    @(negedge clk);
    if (started) begin
      cmp("A", obs_a, model(mode_a, pos, r, key));
      cmp("B", obs_b, model(mode_b, pos, r, key));
      cmp("C", obs_c, model(mode_c, pos, r, key));
    end
    @(posedge clk);
    if (!r) begin
      pos     = 0;
      started = 1'b1;
    end else begin
      pos++;
    end
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pos     = 0;
    started = 1'b0;
    reset_n = 1'b0;
    key     = 24'($urandom);
    mode_a = '{ha: 8, hfp: 2, hs: 3, hbp: 3, va: 4, vfp: 1, vs: 2, vbp: 1,
               lat: 1, fw: 8, hpol: 1'b0, vpol: 1'b0};
    mode_b = '{ha: 8, hfp: 2, hs: 3, hbp: 3, va: 4, vfp: 1, vs: 2, vbp: 1,
               lat: 3, fw: 2, hpol: 1'b1, vpol: 1'b1};
    mode_c = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33,
               lat: 1, fw: 8, hpol: 1'b0, vpol: 1'b0};
    @(posedge clk);
    #1;
    repeat (3) step(1'b0);
    // Reset pulse at h_cnt=9, v_cnt=5 of the first frame
    repeat (89) step(1'b1);
    step(1'b0);
    // Free run across several frames so the 2-bit frame counter wraps
    repeat (700) step(1'b1);
    // Random reset pulses of random length
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) >= 4);
    end
    step(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
